fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch and issue sequencer for the BittyPro core.
- Owns the program counter and the instruction register.
- Reads instructions over a variable-latency memory handshake and hands each non-branch instruction to the control unit, holding it until the control unit reports done.
- Resolves branches locally from the ALU compare flags and handles halt.

Parameters:
- ADDR_W, 8, program counter / instruction memory address width (legal range 4..12).
- RESET_PC, 0, PC value loaded on reset and on each start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins execution from RESET_PC when in IDLE or HALTED.
- mem_addr  output  ADDR_W  instruction fetch address, equals pc.
- mem_rd_en  output  1  one-cycle fetch request.
- mem_rdata  input  16  fetched instruction word, valid when mem_valid=1.
- mem_valid  input  1  read data valid, any latency >=1 cycle after mem_rd_en.
- inst  output  16  instruction presented to the control unit (the instruction register).
- inst_valid  output  1  inst is ready for the control unit to execute.
- cu_done  input  1  control unit completion pulse.
- cmp_flags  input  3  {gt, lt, eq} from the last ALU compare.
- pc  output  ADDR_W  current program counter.
- halted  output  1  high while in HALTED.
- retired  output  CNT_W  count of instructions completed by the control unit, saturating.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-fetch and mid-issue):
  - State goes to IDLE.
  - pc=RESET_PC, inst=0, inst_valid=0, mem_rd_en=0, halted=0, retired=0.
- States: IDLE, FETCH, WAIT_MEM, DECODE, ISSUE, HALTED.
- IDLE: all strobes low. On start=1, pc<=RESET_PC, go to FETCH.
- FETCH:
  - Assert mem_rd_en=1 for exactly this one cycle, with mem_addr=pc.
  - Go to WAIT_MEM.
- WAIT_MEM:
  - mem_addr is held at pc.
  - On mem_valid=1, inst<=mem_rdata, go to DECODE.
  - mem_valid in any other state is ignored.
- DECODE (one cycle), priority in this order:
  - inst==16'hFFFF (HALT): go to HALTED. retired is unchanged.
  - inst[1:0]==2'b10 (BRANCH):
    - Condition field inst[3:2]: 00 EQ (eq), 01 GT (gt), 10 LT (lt), 11 always.
    - Target is inst[ADDR_W+3:4].
    - If taken, pc<=target; otherwise pc<=pc+1.
    - Go to FETCH. The branch is not issued to the control unit and does not increment retired.
  - Otherwise: go to ISSUE.
- ISSUE:
  - inst_valid=1; inst is stable for the whole state.
  - On cu_done=1: pc<=pc+1, retired<=retired+1 (saturating at all-ones), inst_valid drops the next cycle, go to FETCH.
  - cu_done while inst_valid=0 is ignored.
- HALTED:
  - halted=1, all strobes low.
  - start=1 behaves as in IDLE: pc<=RESET_PC, halted cleared, go to FETCH.
  - retired is preserved across restart.
- start outside IDLE and HALTED is ignored.
- pc arithmetic is modulo 2^ADDR_W; pc=all-ones plus 1 wraps to 0.
- Minimum latency per non-branch instruction: FETCH + WAIT_MEM(>=1) + DECODE + ISSUE(>=1) = 4 cycles plus control-unit time.
- Branch latency: 3 cycles plus memory latency.

Decomposition:
- Shared package bitty_pkg holds:
  - state enum.
  - HALT_WORD=16'hFFFF.
  - OPC_BRANCH=2'b10.
  - Condition codes COND_EQ/GT/LT/ALWAYS.
  - Flag bit indices.
- One natural sub-module: branch_eval. It is combinational and maps (cond, cmp_flags) to taken.
- The PC, instruction register and FSM stay in fetch_sequencer.

Test Plan:
- Reset then start; memory returns 16'h2004 after 2 cycles -> mem_rd_en single pulse at addr 0, inst=16'h2004, inst_valid high until cu_done; pc=1, retired=1.
- Branch 16'h0052 (target 5, cond EQ) with cmp_flags=3'b001 -> inst_valid never asserted, next mem_addr=5. Same word with cmp_flags=3'b100 -> next mem_addr=pc+1.
- Fetch 16'hFFFF -> halted=1, no further mem_rd_en. Then start -> halted=0, fetch from RESET_PC, retired unchanged.
- ADDR_W=4, pc=15, non-branch completes -> pc=0; cu_done pulses while in WAIT_MEM -> retired unchanged.
- Assert reset during ISSUE with inst_valid=1 -> next cycle inst_valid=0, pc=RESET_PC, retired=0, state IDLE; a later mem_valid is ignored.
- CNT_W=2, complete 5 instructions -> retired saturates at 3.

Source files
------------

// File: rtl/bitty_pkg.sv
// bitty_pkg: shared fetch-sequencer state encoding, opcode and branch-condition constants
package bitty_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_MEM, S_DECODE, S_ISSUE, S_HALTED} state_t;
    localparam logic [15:0] HALT_WORD   = 16'hFFFF;
    localparam logic [1:0]  OPC_BRANCH  = 2'b10;
    localparam logic [1:0]  COND_EQ     = 2'b00;
    localparam logic [1:0]  COND_GT     = 2'b01;
    localparam logic [1:0]  COND_LT     = 2'b10;
    localparam logic [1:0]  COND_ALWAYS = 2'b11;
    localparam int FLAG_EQ = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_GT = 2;
endpackage

// File: rtl/branch_eval.sv
// branch_eval: maps a branch condition field and the {gt, lt, eq} compare flags to taken
module branch_eval
    import bitty_pkg::*;
(
    input  logic [1:0] cond,
    input  logic [2:0] cmp_flags,
    output logic       taken
);
    always_comb
        taken = cond == COND_EQ ? cmp_flags[FLAG_EQ] :
                cond == COND_GT ? cmp_flags[FLAG_GT] :
                cond == COND_LT ? cmp_flags[FLAG_LT] : 1'b1;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns pc and instruction register, fetches over a variable-latency
// handshake, resolves branches locally and issues other instructions to the control unit
module fetch_sequencer
    import bitty_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       inst,
    output logic              inst_valid,
    input  logic              cu_done,
    input  logic [2:0]        cmp_flags,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    state_t state;
    logic   taken;

    branch_eval u_branch_eval (.cond(inst[3:2]), .cmp_flags(cmp_flags), .taken(taken));

    assign mem_addr = pc;

    // mem_rd_en is raised on every transition into FETCH so it is high for exactly that cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            mem_rd_en  <= 1'b0;
            halted     <= 1'b0;
            retired    <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: if (start) begin
                    pc        <= RESET_PC;
                    halted    <= 1'b0;
                    mem_rd_en <= 1'b1;
                    state     <= S_FETCH;
                end
                S_FETCH: state <= S_WAIT_MEM;
                S_WAIT_MEM: if (mem_valid) begin
                    inst  <= mem_rdata;
                    state <= S_DECODE;
                end
                S_DECODE: if (inst == HALT_WORD) begin
                    halted <= 1'b1;
                    state  <= S_HALTED;
                end else if (inst[1:0] == OPC_BRANCH) begin
                    pc        <= taken ? inst[ADDR_W+3:4] : pc + ADDR_W'(1);
                    mem_rd_en <= 1'b1;
                    state     <= S_FETCH;
                end else begin
                    inst_valid <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: if (cu_done) begin
                    pc         <= pc + ADDR_W'(1);
                    retired    <= retired + CNT_W'(!(&retired));
                    inst_valid <= 1'b0;
                    mem_rd_en  <= 1'b1;
                    state      <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random instruction streams checked against an
// instruction-level model of pc, retired count and halt behaviour
module tb_fetch_sequencer;
    localparam int             AW  = 4;
    localparam int             CW  = 3;
    localparam logic [AW-1:0]  RPC = 4'd3;
    localparam int             SAT = 7;

    logic          clk = 1'b0;
    logic          reset, start, mem_valid, cu_done;
    logic [15:0]   mem_rdata;
    logic [2:0]    cmp_flags;
    logic [AW-1:0] mem_addr, pc;
    logic          mem_rd_en, inst_valid, halted;
    logic [15:0]   inst;
    logic [CW-1:0] retired;

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .inst(inst), .inst_valid(inst_valid),
        .cu_done(cu_done), .cmp_flags(cmp_flags), .pc(pc), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [AW-1:0] m_pc;
    int            m_retired;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit taken_of(input logic [15:0] w, input logic [2:0] f);
        case (w[3:2])
            2'd0:    return f[0];
            2'd1:    return f[2];
            2'd2:    return f[1];
            default: return 1'b1;
        endcase
    endfunction

    // One instruction from its fetch request through completion, as seen from outside
    task automatic exec(input logic [15:0] w, input logic [2:0] f, input int lat,
                        input int cu_lat, input bit stray, input bit rst_issue);
        int n = 0;
        while (!mem_rd_en && n < 10) begin step(); n++; end
        check("fetch_req", 32'(mem_rd_en), 1);
        check("fetch_addr", 32'(mem_addr), 32'(m_pc));
        cmp_flags = f;
        step();
        check("rd_pulse", 32'(mem_rd_en), 0);
        for (int i = 1; i < lat; i++) begin
            cu_done = stray;
            mem_rdata = 16'($urandom);
            step();
        end
        cu_done = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = w;
        step();
        mem_valid = 1'b0;
        mem_rdata = 16'($urandom);
        check("inst_load", 32'(inst), 32'(w));
        check("decode_iv", 32'(inst_valid), 0);
        check("retired_hold", 32'(retired), 32'(m_retired));
        step();
        if (w == 16'hFFFF) begin
            check("halted", 32'(halted), 1);
            repeat (4) begin
                step();
                check("halt_no_fetch", 32'(mem_rd_en), 0);
            end
        end else if (w[1:0] == 2'b10) begin
            m_pc = taken_of(w, f) ? w[AW+3:4] : m_pc + 4'd1;
            check("branch_iv", 32'(inst_valid), 0);
            check("branch_pc", 32'(pc), 32'(m_pc));
        end else begin
            check("issue_iv", 32'(inst_valid), 1);
            for (int i = 0; i < cu_lat; i++) begin
                start = (i == 0);
                step();
                start = 1'b0;
                check("issue_hold_iv", 32'(inst_valid), 1);
                check("issue_hold_inst", 32'(inst), 32'(w));
            end
            if (rst_issue) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                m_pc = RPC;
                m_retired = 0;
                check("rst_iv", 32'(inst_valid), 0);
                check("rst_pc", 32'(pc), 32'(RPC));
                check("rst_retired", 32'(retired), 0);
                check("rst_rd", 32'(mem_rd_en), 0);
                check("rst_inst", 32'(inst), 0);
                return;
            end
            cu_done = 1'b1;
            step();
            cu_done = 1'b0;
            m_pc = m_pc + 4'd1;
            if (m_retired < SAT) m_retired++;
            check("done_iv", 32'(inst_valid), 0);
            check("done_pc", 32'(pc), 32'(m_pc));
            check("done_retired", 32'(retired), 32'(m_retired));
        end
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b1; start = 1'b0; mem_valid = 1'b0; cu_done = 1'b0;
        mem_rdata = '0; cmp_flags = '0;
        repeat (2) step();
        check("reset_pc", 32'(pc), 32'(RPC));
        check("reset_inst", 32'(inst), 0);
        check("reset_iv", 32'(inst_valid), 0);
        check("reset_rd", 32'(mem_rd_en), 0);
        check("reset_halted", 32'(halted), 0);
        check("reset_retired", 32'(retired), 0);
        reset = 1'b0;
        m_pc = RPC;
        m_retired = 0;
        repeat (2) step();
        check("idle_no_fetch", 32'(mem_rd_en), 0);
        start = 1'b1; step(); start = 1'b0;
        exec(16'h2004, 3'b000, 2, 1, 1'b1, 1'b0);
        exec(16'h0052, 3'b001, 1, 0, 1'b0, 1'b0);
        exec(16'h0052, 3'b100, 1, 0, 1'b0, 1'b0);
        exec(16'h00FE, 3'b000, 3, 0, 1'b1, 1'b0);
        exec(16'h1234, 3'b000, 1, 2, 1'b0, 1'b0);
        check("pc_wrap", 32'(pc), 0);
        exec(16'hFFFF, 3'b000, 2, 0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check("restart_halted", 32'(halted), 0);
        check("restart_rd", 32'(mem_rd_en), 1);
        check("restart_addr", 32'(mem_addr), 32'(RPC));
        check("restart_retired", 32'(retired), 32'(m_retired));
        m_pc = RPC;
        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[1:0] = 2'b10;
            else if (w[1:0] == 2'b10) w[0] = 1'b1;
            if (w == 16'hFFFF) w[15] = 1'b0;
            exec(w, 3'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        check("retired_sat", 32'(retired), 32'(m_retired));
        exec(16'h0004, 3'b000, 1, 1, 1'b0, 1'b1);
        mem_valid = 1'b1;
        mem_rdata = 16'hABCD;
        repeat (3) step();
        mem_valid = 1'b0;
        check("idle_ignore_inst", 32'(inst), 0);
        check("idle_ignore_rd", 32'(mem_rd_en), 0);
        check("idle_ignore_pc", 32'(pc), 32'(RPC));
        start = 1'b1; step(); start = 1'b0;
        exec(16'h0010, 3'b000, 1, 0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
